// File: rtl/poly_note_gen_if.sv
// Control and audio bundle for the polyphonic square-wave note generator.
// The master side drives the keyboard/controls; the slave side is the generator.
interface poly_note_gen_if;
    logic [511:0]       key_down;
    logic [1:0]         octave;
    logic [2:0]         vol;
    logic               mono;
    logic signed [15:0] audio_in_left;
    logic signed [15:0] audio_in_right;

    modport master (
        output key_down, octave, vol, mono,
        input  audio_in_left, audio_in_right
    );

    modport slave (
        input  key_down, octave, vol, mono,
        output audio_in_left, audio_in_right
    );
endinterface

// File: rtl/poly_note_gen.sv
// Polyphonic/monophonic square-wave tone generator: a 7-step key scanner assigns
// held notes to voices, each voice toggles at its half-period, and the mixer saturates.
module poly_note_gen #(
    parameter int                 CLK_HZ     = 100000000,
    parameter int                 NUM_VOICES = 4,
    parameter logic signed [15:0] AMP        = 16'sh1FFF
) (
    input logic            clk,
    input logic            rst,
    poly_note_gen_if.slave bus
);
    localparam int NOTES = 7;

    function automatic int note_freq(input int idx);
        case (idx)
            0:       return 262;
            1:       return 294;
            2:       return 330;
            3:       return 349;
            4:       return 392;
            5:       return 440;
            default: return 494;
        endcase
    endfunction

    function automatic logic [8:0] note_code(input int idx);
        case (idx)
            0:       return 9'h01C;
            1:       return 9'h032;
            2:       return 9'h021;
            3:       return 9'h023;
            4:       return 9'h024;
            5:       return 9'h02B;
            default: return 9'h034;
        endcase
    endfunction

    function automatic logic [31:0] calc_hp(input int idx);
        int q;
        q = CLK_HZ / (2 * note_freq(idx));
        return (q == 0) ? 32'd1 : 32'(q);
    endfunction

    // Table padded to 8 entries so the 3-bit scan index never leaves the array.
    logic [31:0] hp_tab [8];
    logic [7:0]  key_held;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_note
            if (gi < NOTES) begin : g_used
                localparam logic [8:0]  CODE = note_code(gi);
                localparam logic [31:0] HP   = calc_hp(gi);
                assign hp_tab[gi]   = HP;
                assign key_held[gi] = bus.key_down[CODE];
            end else begin : g_pad
                assign hp_tab[gi]   = 32'd1;
                assign key_held[gi] = 1'b0;
            end
        end
    endgenerate

    logic unused_keys;
    assign unused_keys = ^bus.key_down;

    logic [2:0]         scan_idx_reg;
    logic               mono_prev_reg;
    logic signed [15:0] audio_reg;

    logic        active_reg [NUM_VOICES];
    logic [2:0]  note_reg   [NUM_VOICES];
    logic [31:0] hp_reg     [NUM_VOICES];
    logic [31:0] cnt_reg    [NUM_VOICES];
    logic        phase_reg  [NUM_VOICES];

    logic        active_next [NUM_VOICES];
    logic [2:0]  note_next   [NUM_VOICES];
    logic [31:0] hp_next     [NUM_VOICES];
    logic [31:0] cnt_next    [NUM_VOICES];
    logic        phase_next  [NUM_VOICES];

    // Lowest-index held note, used by monophonic priority.
    logic       low_found;
    logic [2:0] low_idx;

    always_comb begin
        low_found = 1'b0;
        low_idx   = 3'd0;
        for (int n = NOTES - 1; n >= 0; n--) begin
            if (key_held[n]) begin
                low_found = 1'b1;
                low_idx   = 3'(n);
            end
        end
    end

    logic        key_now;
    logic        mono_changed;
    logic        mono_note_differs;
    logic [2:0]  sel_note;
    logic [31:0] hp_shifted;
    logic [31:0] eff_hp;

    assign key_now           = key_held[scan_idx_reg];
    assign mono_changed      = bus.mono != mono_prev_reg;
    assign mono_note_differs = !active_reg[0] || (note_reg[0] != low_idx);
    assign sel_note          = bus.mono ? low_idx : scan_idx_reg;
    assign hp_shifted        = hp_tab[sel_note] >> bus.octave;
    assign eff_hp            = (hp_shifted == 32'd0) ? 32'd1 : hp_shifted;

    logic assigned;
    logic free_seen;

    always_comb begin
        assigned = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (active_reg[v] && note_reg[v] == scan_idx_reg)
                assigned = 1'b1;
        end

        free_seen = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            active_next[v] = active_reg[v];
            note_next[v]   = note_reg[v];
            hp_next[v]     = hp_reg[v];
            cnt_next[v]    = cnt_reg[v];
            phase_next[v]  = phase_reg[v];

            if (active_reg[v]) begin
                if (cnt_reg[v] == hp_reg[v] - 32'd1) begin
                    cnt_next[v]   = 32'd0;
                    phase_next[v] = ~phase_reg[v];
                end else begin
                    cnt_next[v] = cnt_reg[v] + 32'd1;
                end
            end

            // Allocation decisions override the free-running tone advance.
            if (mono_changed || (bus.mono && v != 0)) begin
                active_next[v] = 1'b0;
                cnt_next[v]    = 32'd0;
                phase_next[v]  = 1'b0;
            end else if (bus.mono) begin
                if (scan_idx_reg == 3'd6) begin
                    if (!low_found) begin
                        active_next[v] = 1'b0;
                        cnt_next[v]    = 32'd0;
                        phase_next[v]  = 1'b0;
                    end else if (mono_note_differs) begin
                        active_next[v] = 1'b1;
                        note_next[v]   = low_idx;
                        hp_next[v]     = eff_hp;
                        cnt_next[v]    = 32'd0;
                        phase_next[v]  = 1'b1;
                    end
                end
            end else begin
                if (!key_now && active_reg[v] && note_reg[v] == scan_idx_reg) begin
                    active_next[v] = 1'b0;
                    cnt_next[v]    = 32'd0;
                    phase_next[v]  = 1'b0;
                end else if (key_now && !assigned && !active_reg[v] && !free_seen) begin
                    active_next[v] = 1'b1;
                    note_next[v]   = scan_idx_reg;
                    hp_next[v]     = eff_hp;
                    cnt_next[v]    = 32'd0;
                    phase_next[v]  = 1'b1;
                end
                if (!active_reg[v])
                    free_seen = 1'b1;
            end
        end
    end

    logic signed [15:0] amp_sh;
    logic signed [18:0] amp_ext;
    logic signed [18:0] contrib [NUM_VOICES];
    logic signed [18:0] mix_sum;
    logic signed [15:0] mix_sat;

    assign amp_sh  = AMP >>> bus.vol;
    assign amp_ext = {{3{amp_sh[15]}}, amp_sh};

    generate
        for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            assign contrib[gi] = !active_reg[gi] ? 19'sd0
                               : (phase_reg[gi] ? amp_ext : -amp_ext);
        end
    endgenerate

    always_comb begin
        mix_sum = 19'sd0;
        for (int v = 0; v < NUM_VOICES; v++)
            mix_sum = mix_sum + contrib[v];
        if (mix_sum > 19'sd32767)
            mix_sat = 16'sh7FFF;
        else if (mix_sum < -19'sd32768)
            mix_sat = 16'sh8000;
        else
            mix_sat = mix_sum[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_idx_reg  <= 3'd0;
            mono_prev_reg <= 1'b0;
            audio_reg     <= 16'sh0000;
            for (int v = 0; v < NUM_VOICES; v++) begin
                active_reg[v] <= 1'b0;
                note_reg[v]   <= 3'd0;
                hp_reg[v]     <= 32'd0;
                cnt_reg[v]    <= 32'd0;
                phase_reg[v]  <= 1'b0;
            end
        end else begin
            scan_idx_reg  <= (scan_idx_reg == 3'd6) ? 3'd0 : scan_idx_reg + 3'd1;
            mono_prev_reg <= bus.mono;
            audio_reg     <= mix_sat;
            active_reg    <= active_next;
            note_reg      <= note_next;
            hp_reg        <= hp_next;
            cnt_reg       <= cnt_next;
            phase_reg     <= phase_next;
        end
    end

    assign bus.audio_in_left  = audio_reg;
    assign bus.audio_in_right = audio_reg;
endmodule

// File: tb/tb_poly_note_gen.sv
// Scoreboard bench for poly_note_gen: stimulus queues expected samples by cycle,
// a negedge monitor pops and compares them against both audio outputs.
module tb_poly_note_gen;
    localparam int CLK_HZ = 100000;   // half-periods C4..B4: 190,170,151,143,127,113,101
    localparam int NV     = 4;
    localparam int A      = 16383;    // AMP = 16'h3FFF at vol 0

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tcyc = 0;
    int   R = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    int    cyc_q [$];
    int    val_q [$];
    string tag_q [$];

    poly_note_gen_if bus();

    poly_note_gen #(
        .CLK_HZ    (CLK_HZ),
        .NUM_VOICES(NV),
        .AMP       (16'sh3FFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tcyc <= tcyc + 1;

    task automatic expect_at(input int cyc, input int val, input string tag);
        cyc_q.push_back(cyc);
        val_q.push_back(val);
        tag_q.push_back(tag);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int n);
        while (tcyc < n) step(1);
    endtask

    // Return just after an edge such that the following edge scans index i.
    task automatic align(input int i);
        while (((tcyc - R) % 7) != i) step(1);
    endtask

    always @(negedge clk) begin
        int    c;
        int    v;
        string t;
        while (cyc_q.size() > 0 && cyc_q[0] <= tcyc) begin
            c = cyc_q.pop_front();
            v = val_q.pop_front();
            t = tag_q.pop_front();
            n_checks++;
            if (c != tcyc) begin
                n_fail++;
                $display("FAIL %s: sample for cycle %0d missed at cycle %0d, required %0d", t, c, tcyc, v);
            end else if (bus.audio_in_left !== 16'(v) || bus.audio_in_right !== 16'(v)) begin
                n_fail++;
                $display("FAIL %s: cycle %0d left=%0d right=%0d required %0d",
                         t, tcyc, bus.audio_in_left, bus.audio_in_right, v);
            end else begin
                $display("ok   %s: cycle %0d output %0d", t, tcyc, v);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", tcyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c, k, e, d, c2;
        bus.key_down = '0;
        bus.octave   = 2'd0;
        bus.vol      = 3'd0;
        bus.mono     = 1'b0;

        step(3);
        expect_at(tcyc + 1, 0, "reset_hold");
        step(2);

        // Single C4 note held across reset release
        bus.key_down[9'h01C] = 1'b1;
        rst = 1'b0;
        R   = tcyc;
        k   = R + 1;
        expect_at(k,       0,  "a_latency");
        expect_at(k + 1,   A,  "a_first_high");
        expect_at(k + 190, A,  "a_last_high");
        expect_at(k + 191, -A, "a_first_low");
        expect_at(k + 380, -A, "a_last_low");
        expect_at(k + 381, A,  "a_second_high");
        step_to(k + 382);
        align(0);
        bus.key_down[9'h01C] = 1'b0;
        e = tcyc;
        expect_at(e + 2, 0, "a_release");
        step_to(e + 3);

        // C4 + A4 mix
        align(0);
        c = tcyc;
        k = c + 1;
        bus.key_down[9'h01C] = 1'b1;
        bus.key_down[9'h02B] = 1'b1;
        expect_at(k + 1,   A,      "b_c4_only");
        expect_at(k + 5,   A,      "b_before_a4");
        expect_at(k + 6,   2 * A,  "b_both_high");
        expect_at(k + 118, 2 * A,  "b_a4_last_high");
        expect_at(k + 119, 0,      "b_a4_low");
        expect_at(k + 191, -2 * A, "b_both_low");
        expect_at(k + 231, -2 * A, "b_a4_last_low");
        expect_at(k + 232, 0,      "b_a4_high_again");
        step_to(k + 233);
        bus.key_down = '0;
        c2 = tcyc;
        expect_at(c2 + 9, 0, "b_release");
        step_to(c2 + 10);

        // Four voices saturate, vol change, fifth key starved then assigned
        align(0);
        c = tcyc;
        bus.key_down[9'h01C] = 1'b1;
        bus.key_down[9'h032] = 1'b1;
        bus.key_down[9'h021] = 1'b1;
        bus.key_down[9'h023] = 1'b1;
        expect_at(c + 2, A,     "c_one_voice");
        expect_at(c + 3, 2 * A, "c_two_voices");
        expect_at(c + 4, 32767, "c_three_sat");
        expect_at(c + 5, 32767, "c_four_sat");
        step_to(c + 5);
        bus.vol = 3'd2;
        expect_at(c + 6, 16380, "c_vol_change");
        step_to(c + 6);
        bus.key_down[9'h024] = 1'b1;
        expect_at(c + 13, 16380, "d_fifth_silent");
        step_to(c + 13);
        align(1);
        d = tcyc;
        bus.key_down[9'h032] = 1'b0;
        expect_at(d + 2, 12285, "d_after_release");
        expect_at(d + 4, 12285, "d_before_reassign");
        expect_at(d + 5, 16380, "d_fifth_assigned");
        step_to(d + 6);
        bus.key_down = '0;
        bus.vol      = 3'd0;
        c2 = tcyc;
        expect_at(c2 + 9, 0, "d_release");
        step_to(c2 + 10);

        // Monophonic priority: D4 wins over G4, then G4 after D4 release
        align(0);
        c = tcyc;
        bus.mono             = 1'b1;
        bus.key_down[9'h024] = 1'b1;
        bus.key_down[9'h032] = 1'b1;
        expect_at(c + 7,   0,  "e_mono_wait");
        expect_at(c + 8,   A,  "e_mono_d4");
        expect_at(c + 177, A,  "e_d4_last_high");
        expect_at(c + 178, -A, "e_d4_half_period");
        step_to(c + 178);
        align(6);
        e = tcyc;
        bus.key_down[9'h032] = 1'b0;
        expect_at(e + 1,   -A, "e_d4_still");
        expect_at(e + 2,   A,  "e_g4_start");
        expect_at(e + 128, A,  "e_g4_last_high");
        expect_at(e + 129, -A, "e_g4_half_period");
        step_to(e + 130);
        bus.key_down = '0;
        bus.mono     = 1'b0;
        c2 = tcyc;
        expect_at(c2 + 9, 0, "e_release");
        step_to(c2 + 10);

        // Octave shift on A4, then asynchronous reset mid-tone
        bus.octave = 2'd3;
        align(5);
        e = tcyc;
        k = e + 1;
        bus.key_down[9'h02B] = 1'b1;
        expect_at(k + 1,  A,  "f_oct3_high");
        expect_at(k + 14, A,  "f_oct3_last_high");
        expect_at(k + 15, -A, "f_oct3_half_period");
        expect_at(k + 28, -A, "f_oct3_last_low");
        expect_at(k + 29, A,  "f_oct3_period");
        step_to(k + 30);
        #1;
        rst = 1'b1;
        expect_at(tcyc, 0, "f_async_reset");
        step(2);
        bus.key_down = '0;
        expect_at(tcyc + 1, 0, "f_reset_hold");

        for (int i = 0; i < 20 && cyc_q.size() > 0; i++) step(1);
        if (cyc_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d samples still pending, required 0", cyc_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/poly_note_gen.md
POLY_NOTE_GEN -- requirements
Module: poly_note_gen

Interface
REQ-001 Parameter CLK_HZ, default 100000000, input clock frequency in Hz.
REQ-002 Parameter NUM_VOICES, default 4, number of simultaneous tone voices (1..7).
REQ-003 Parameter AMP, default 16'h1FFF, per-voice peak amplitude (positive signed value).
REQ-004 Port clk, input, 1, single system clock.
REQ-005 Port rst, input, 1, asynchronous active-high reset.
REQ-006 Port key_down, input, 512, one bit per key scan code, 1 = held.
REQ-007 Port octave, input, 2, octave shift 0..3 above octave 4.
REQ-008 Port vol, input, 3, attenuation as an arithmetic right shift of AMP (0 = full level).
REQ-009 Port mono, input, 1, 1 = monophonic priority mode, 0 = polyphonic mode.
REQ-010 Port audio_in_left, output, 16, signed mixed sample, registered.
REQ-011 Port audio_in_right, output, 16, identical to audio_in_left.
REQ-012 One clock only; reset is asynchronous and active-high.

Function
REQ-013 Note table, index 0..6: scan codes 0x01C, 0x032, 0x021, 0x023, 0x024, 0x02B, 0x034 map to C4 262, D4 294, E4 330, F4 349, G4 392, A4 440, B4 494 Hz.
REQ-014 Base half-period HP[i] = floor(CLK_HZ / (2*f[i])), elaboration-time constant; any result of 0 forced to 1.
REQ-015 Effective half-period = HP[i] >> octave, floored at 1, sampled only at voice assignment.
REQ-016 Voice state: active flag, 3-bit note index, 32-bit half-period, 32-bit counter, phase bit.
REQ-017 Scanner: 3-bit index stepping 0,1,...,6,0 one per clock; 7-cycle pass; no idle states.
REQ-018 Poly scan at index i, key held and not assigned: lowest-index free voice takes note i; counter=0, phase=1 on the next edge.
REQ-019 Poly scan at index i, key held and no voice free: key ignored this pass, retried on later passes.
REQ-020 Poly scan at index i, key released and assigned: that voice goes inactive on the next edge; counter=0, phase=0.
REQ-021 A note never occupies more than one voice.
REQ-022 Mono mode: voice 0 only; at scan index 6 it takes the lowest-index held note. It reloads only if the note differs; it goes inactive if no note is held. Voices 1..NUM_VOICES-1 inactive.
REQ-023 Any change of mono frees all voices on the next edge; allocation restarts from the current scan index.
REQ-024 Active voice tone: counter increments each clock. At counter == half-period-1: counter=0, phase toggles.
REQ-025 Voice contribution: +(AMP>>>vol) if phase=1, -(AMP>>>vol) if phase=0, 0 if inactive.
REQ-026 Mixer: sum of all contributions in at least 19-bit signed arithmetic, saturated to [-32768, 32767], registered into audio_in_left.
REQ-027 Output latency is 1 clock from any voice phase/active change to audio_in_left.
REQ-028 octave or vol changes mid-note: octave affects only later assignments; vol takes effect on the next output register update.

Reset
REQ-029 While rst=1: all voices inactive; counters, half-periods, phases and scan index 0; audio_in_left = audio_in_right = 16'h0000.
REQ-030 After rst deasserts, scanning starts at index 0 on the first clock edge; reset mid-note silences output asynchronously.

Verification
REQ-031 Defaults, key_down[0x01C]=1, octave=0, vol=0, mono=0 -> within 7 cycles output +8191. It alternates +8191/-8191 every 190839 cycles.
REQ-032 Keys 0x01C and 0x02B held -> output takes values from {16382, 0, -16382}. Component periods are 2*190839 and 2*113636 cycles.
REQ-033 AMP=16'h3FFF, NUM_VOICES=4, keys 0x01C, 0x032, 0x021, 0x023 pressed on the same cycle -> all in phase at start; output saturates to 32767.
REQ-034 NUM_VOICES=4, five keys held -> fifth-scanned key silent. Release one assigned key -> fifth key assigned within 14 cycles.
REQ-035 mono=1, keys 0x024 and 0x032 held -> only D4 sounds (HP 170068). Release 0x032 -> G4 (HP 127551) within 7 cycles.
REQ-036 octave=3 then key 0x02B -> half-period 14204. Assert rst mid-tone -> output 0 immediately, all voices inactive.
